// File: rtl/qspi_xip_flash_responder_if.sv
// Quad-SPI link between an XIP cache controller and the flash-side responder,
// plus the responder's port to its synchronous byte memory.
interface qspi_xip_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  sck;
  logic                  ce_n;
  logic [3:0]            din;
  logic [3:0]            dout;
  logic [3:0]            douten;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic [7:0]            mem_rdata;

  // Responder (flash) side
  modport slave (
    input  sck, ce_n, din, mem_rdata,
    output dout, douten, mem_addr, mem_rd
  );

  // Controller plus backing-memory side
  modport master (
    output sck, ce_n, din, mem_rdata,
    input  dout, douten, mem_addr, mem_rd
  );
endinterface

// File: rtl/qspi_xip_flash_responder.sv
// Flash-side responder for Fast Read Quad I/O (EBh). sck is oversampled on
// HCLK; reads come from a synchronous byte memory with one-cycle latency.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ce_n high, waiting for a transaction
// S_CMD    | shifting 8 command bits on din[0]
// S_ADDR   | shifting 6 address nibbles
// S_MODE   | shifting 2 mode nibbles, decides continuous-read mode
// S_DUMMY  | counting dummy clocks, first rise fetches byte 0
// S_DATA   | driving nibbles on falling sck, prefetching next byte
// S_IGNORE | unsupported command, stay quiet until ce_n rises
module qspi_xip_flash_responder #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned DUMMY_CLKS   = 4,
  parameter bit          CONT_MODE_EN = 1'b1
) (
  input logic                        HCLK,
  input logic                        HRESETn,
  qspi_xip_flash_responder_if.slave  qspi
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sck_sync_q, ce_sync_q;
  logic [3:0]            din_s1_q, din_s2_q;
  logic                  sck_prev_q;
  logic [7:0]            cnt_q, cnt_d;
  logic [19:0]           sr_q, sr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  rd_pend_q;
  logic [7:0]            pre_q;
  logic [3:0]            hold_q, hold_d;
  logic                  nib_lo_q, nib_lo_d;
  logic                  cont_q, cont_d;
  logic [3:0]            dout_q, dout_d;
  logic [3:0]            douten_q, douten_d;
  logic                  ce_s, rise, fall;

  assign ce_s = ce_sync_q[1];
  assign rise = sck_sync_q[1] & ~sck_prev_q;
  assign fall = ~sck_sync_q[1] & sck_prev_q;

  assign qspi.dout     = dout_q;
  assign qspi.douten   = douten_q;
  assign qspi.mem_addr = mem_addr_q;
  assign qspi.mem_rd   = mem_rd_q;

  // Pin synchronisers, edge history and the memory-read capture path.
  // ce_n resets to its inactive level so no transaction starts out of reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sck_sync_q <= 2'b00;
      ce_sync_q  <= 2'b11;
      din_s1_q   <= 4'h0;
      din_s2_q   <= 4'h0;
      sck_prev_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      pre_q      <= 8'h00;
    end else begin
      sck_sync_q <= {sck_sync_q[0], qspi.sck};
      ce_sync_q  <= {ce_sync_q[0], qspi.ce_n};
      din_s1_q   <= qspi.din;
      din_s2_q   <= din_s1_q;
      sck_prev_q <= sck_sync_q[1];
      rd_pend_q  <= mem_rd_q;
      if (rd_pend_q) pre_q <= qspi.mem_rdata;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'h00;
      sr_q       <= 20'h0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      hold_q     <= 4'h0;
      nib_lo_q   <= 1'b0;
      cont_q     <= 1'b0;
      dout_q     <= 4'h0;
      douten_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      hold_q     <= hold_d;
      nib_lo_q   <= nib_lo_d;
      cont_q     <= cont_d;
      dout_q     <= dout_d;
      douten_q   <= douten_d;
    end
  end

  // Next-state and output decode; ce_n high overrides any sck edge.
  // The low nibble is kept in hold_q when the high nibble goes out, so the
  // prefetch landing in pre_q cannot disturb the byte being transmitted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    hold_d     = hold_q;
    nib_lo_d   = nib_lo_q;
    cont_d     = cont_q;
    dout_d     = dout_q;
    douten_d   = douten_q;
    if (ce_s) begin
      state_d  = S_IDLE;
      cnt_d    = 8'h00;
      nib_lo_d = 1'b0;
      dout_d   = 4'h0;
      douten_d = 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // cont flag survives only if this transaction completes its mode phase
          state_d = cont_q ? S_ADDR : S_CMD;
          cont_d  = 1'b0;
          cnt_d   = 8'h00;
        end
        S_CMD: if (rise) begin
          sr_d  = {sr_q[18:0], din_s2_q[0]};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'h00;
            state_d = (sr_d[7:0] == 8'hEB) ? S_ADDR : S_IGNORE;
          end
        end
        S_ADDR: if (rise) begin
          sr_d  = {sr_q[15:0], din_s2_q};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d      = 8'h00;
            mem_addr_d = ADDR_WIDTH'({sr_q[19:0], din_s2_q});
            state_d    = S_MODE;
          end
        end
        S_MODE: if (rise) begin
          sr_d  = {sr_q[15:0], din_s2_q};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            cnt_d   = 8'h00;
            cont_d  = CONT_MODE_EN && (sr_d[5:4] == 2'b10);
            state_d = S_DUMMY;
          end
        end
        S_DUMMY: if (rise) begin
          if (cnt_q == 8'd0) mem_rd_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
            cnt_d    = 8'h00;
            nib_lo_d = 1'b0;
            state_d  = S_DATA;
          end
        end
        S_DATA: if (fall) begin
          douten_d = 4'hF;
          if (!nib_lo_q) begin
            dout_d     = pre_q[7:4];
            hold_d     = pre_q[3:0];
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            mem_rd_d   = 1'b1;
            nib_lo_d   = 1'b1;
          end else begin
            dout_d   = hold_q;
            nib_lo_d = 1'b0;
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_xip_flash_responder.sv
// Bench for qspi_xip_flash_responder: acts as the XIP controller and backing
// memory, with a scoreboard of expected data nibbles checked on sck rises.
module tb_qspi_xip_flash_responder;
  localparam int AW    = 8;
  localparam int DUMMY = 4;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  qspi_xip_flash_responder_if #(.ADDR_WIDTH(AW)) qspi ();

  qspi_xip_flash_responder #(
    .ADDR_WIDTH(AW), .DUMMY_CLKS(DUMMY), .CONT_MODE_EN(1'b1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .qspi(qspi)
  );

  always #5 HCLK = ~HCLK;

  logic [7:0] mem [256];
  always @(posedge HCLK) if (qspi.mem_rd) qspi.mem_rdata <= mem[qspi.mem_addr];

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] sb[$];
  bit         quiet = 1'b1;
  bit         rd_allowed = 1'b0;
  logic [7:0] exp_rd = 8'h00;
  logic       rd_prev = 1'b0;
  bit         cont_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data monitor: every sck rise with the bus enabled consumes one expected nibble
  always @(posedge qspi.sck) begin
    if (qspi.douten !== 4'h0) begin
      vectors++;
      if (qspi.douten !== 4'hF || sb.size() == 0 || qspi.dout !== sb[0]) begin
        miscompares++;
        $display("FAIL data_nibble: douten=%h dout=%h expected douten=f dout=%h (queued %0d) at %0t",
                 qspi.douten, qspi.dout, (sb.size() != 0) ? sb[0] : 4'hx, sb.size(), $time);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  // Bus-quiet and memory-strobe monitor
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (quiet) begin
        vectors++;
        if (qspi.douten !== 4'h0 || qspi.dout !== 4'h0) begin
          miscompares++;
          $display("FAIL bus_quiet: douten=%h dout=%h expected 0 and 0 at %0t",
                   qspi.douten, qspi.dout, $time);
        end
      end
      if (qspi.mem_rd === 1'b1) begin
        vectors++;
        if (!rd_allowed || rd_prev || qspi.mem_addr !== exp_rd) begin
          miscompares++;
          $display("FAIL mem_rd: addr=%h expected addr=%h allowed=%0d prev_rd=%0d at %0t",
                   qspi.mem_addr, exp_rd, rd_allowed, rd_prev, $time);
        end
        exp_rd = exp_rd + 8'd1;
      end
      rd_prev = qspi.mem_rd;
    end
  end

  task automatic sclk(input logic [3:0] d);
    qspi.din = d;
    #50 qspi.sck = 1'b1;
    #50 qspi.sck = 1'b0;
  endtask

  task automatic tx_begin;
    qspi.ce_n = 1'b0;
    #50;
  endtask

  task automatic tx_end;
    #50 qspi.ce_n = 1'b1;
    #30;
    quiet      = 1'b1;
    rd_allowed = 1'b0;
    chk("off_after_ce", 32'({qspi.douten, qspi.dout}), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    sb.delete();
    #70;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    logic [3:0] r;
    for (int i = 7; i >= 0; i--) begin
      r    = 4'($urandom);
      r[0] = c[i];
      sclk(r);
    end
  endtask

  // Command (unless in continuous mode), address, mode and dummy clocks
  task automatic hdr(input logic [23:0] addr, input logic [7:0] mode);
    tx_begin();
    if (!cont_m) send_cmd(8'hEB);
    for (int i = 5; i >= 0; i--) sclk(addr[i*4 +: 4]);
    sclk(mode[7:4]);
    sclk(mode[3:0]);
    for (int i = 0; i < DUMMY; i++) begin
      if (i == DUMMY - 1) quiet = 1'b0;
      sclk(4'($urandom));
    end
  endtask

  // Reference: bytes come from mem at address modulo 2^AW, high nibble first
  task automatic push_bytes(input logic [23:0] addr, input int n);
    logic [7:0] a;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      a = addr[7:0] + 8'(k);
      b = mem[a];
      sb.push_back(b[7:4]);
      sb.push_back(b[3:0]);
    end
  endtask

  task automatic read(input logic [23:0] addr, input logic [7:0] mode, input int n);
    push_bytes(addr, n);
    exp_rd     = addr[7:0];
    rd_allowed = 1'b1;
    hdr(addr, mode);
    for (int i = 0; i < 2 * n; i++) sclk(4'($urandom));
    tx_end();
    cont_m = (mode[5:4] == 2'b10);
  endtask

  task automatic ignore_tx(input logic [7:0] c, input int nclk);
    quiet      = 1'b1;
    rd_allowed = 1'b0;
    tx_begin();
    send_cmd(c);
    for (int i = 0; i < nclk; i++) sclk(4'($urandom));
    tx_end();
    cont_m = 1'b0;
  endtask

  task automatic abort_tx(input int nnib);
    quiet      = 1'b1;
    rd_allowed = 1'b0;
    tx_begin();
    send_cmd(8'hEB);
    for (int i = 0; i < nnib; i++) sclk(4'($urandom));
    tx_end();
    cont_m = 1'b0;
  endtask

  initial begin
    logic [23:0] ra;
    logic [7:0]  rm;
    logic [7:0]  rc;
    int          kind;
    qspi.sck  = 1'b0;
    qspi.ce_n = 1'b1;
    qspi.din  = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    #20;
    chk("rst_dout", 32'(qspi.dout), 32'h0);
    chk("rst_douten", 32'(qspi.douten), 32'h0);
    chk("rst_mem_rd", 32'(qspi.mem_rd), 32'h0);
    chk("rst_mem_addr", 32'(qspi.mem_addr), 32'h0);
    #20 HRESETn = 1'b1;
    #100;

    read(24'h000000, 8'h00, 4);
    read(24'h0000FE, 8'h00, 4);
    ignore_tx(8'h9F, 16);
    read(24'h000010, 8'h00, 2);
    abort_tx(3);
    read(24'h000020, 8'h00, 2);
    read(24'h000004, 8'hA0, 1);
    read(24'h000008, 8'hA0, 2);
    read(24'h00000C, 8'h00, 1);
    read(24'h000030, 8'h00, 1);

    // Reset during the data phase of a continuous-mode transaction
    read(24'h000040, 8'hA0, 1);
    push_bytes(24'h000050, 1);
    exp_rd     = 8'h50;
    rd_allowed = 1'b1;
    hdr(24'h000050, 8'h00);
    sclk(4'($urandom));
    sclk(4'($urandom));
    #23 HRESETn = 1'b0;
    #1;
    chk("rst_mid_dout", 32'(qspi.dout), 32'h0);
    chk("rst_mid_douten", 32'(qspi.douten), 32'h0);
    chk("rst_mid_mem_rd", 32'(qspi.mem_rd), 32'h0);
    chk("rst_mid_mem_addr", 32'(qspi.mem_addr), 32'h0);
    rd_allowed = 1'b0;
    quiet      = 1'b1;
    #16 qspi.ce_n = 1'b1;
    chk("rst_mid_sb", 32'(sb.size()), 32'h0);
    sb.delete();
    cont_m = 1'b0;
    #30 HRESETn = 1'b1;
    #100;
    read(24'h000000, 8'h00, 2);

    // Randomised traffic over random memory contents
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      if (!cont_m && kind == 0) begin
        rc = 8'($urandom);
        if (rc == 8'hEB) rc = 8'h9F;
        ignore_tx(rc, $urandom_range(4, 20));
      end else if (!cont_m && kind == 1) begin
        abort_tx($urandom_range(0, 7));
      end else begin
        ra = 24'($urandom);
        rm = 8'($urandom);
        if ($urandom_range(0, 2) == 0) rm[5:4] = 2'b10;
        read(ra, rm, $urandom_range(1, 4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
